// File: rtl/rr_mux_4.sv
// -----------------------------------------------------------------------------
// rr_mux_4
//
// Four-channel round-robin multiplexer with a one-entry registered output.
// Each cycle a winner is picked among the channels that offer data. The search
// starts one position after the last channel granted, so priority rotates and
// no channel starves. The winning word is captured into the output register
// whenever that register is empty or is being drained in the same cycle. This
// allows one word per cycle with no bubble.
//
// Parameters
//   N        data width of every channel and of the output (default 64)
//
// Ports
//   i_clk    clock; all state changes on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_in0..3 channel data, N bits each
//   i_valid  per-channel "data offered" flags
//   o_ready  per-channel accept strobe (one-hot on the winner, or zero)
//   o_out    registered data of the selected channel
//   o_valid  o_out holds a word not yet taken downstream
//   i_ready  downstream accepts o_out this cycle
//   o_src    index of the channel whose word is in o_out
// -----------------------------------------------------------------------------
module rr_mux_4 #(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_in0,
    input  logic [N-1:0] i_in1,
    input  logic [N-1:0] i_in2,
    input  logic [N-1:0] i_in3,
    input  logic [3:0]   i_valid,
    output logic [3:0]   o_ready,
    output logic [N-1:0] o_out,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [1:0]   o_src
);

    // Channel data gathered into an array so the winner can index it.
    logic [N-1:0] chan_data [4];

    assign chan_data[0] = i_in0;
    assign chan_data[1] = i_in1;
    assign chan_data[2] = i_in2;
    assign chan_data[3] = i_in3;

    // Architectural state
    logic [N-1:0] out_reg;
    logic [1:0]   src_reg;
    logic         valid_reg;
    logic [1:0]   last_grant_reg;

    // Combinational control
    logic         any_valid;
    logic         can_load;
    logic         load;
    logic [1:0]   winner;
    logic [1:0]   probe;

    assign any_valid = |i_valid;

    // The output register can take a new word if it is empty or is being
    // emptied by the consumer in this same cycle.
    assign can_load  = !valid_reg || i_ready;

    // Reset is folded in so that o_ready is forced low while reset is held,
    // even though the register state is already cleared by then.
    assign load      = i_rst_n && can_load && any_valid;

    // Rotating priority search. Offsets are walked from farthest to nearest,
    // so the last hit that is written is the channel closest after
    // last_grant. The last_grant itself has the lowest priority (offset 4).
    always_comb begin
        winner = last_grant_reg;
        probe  = last_grant_reg;
        for (int off = 3; off >= 0; off--) begin
            probe = last_grant_reg + 2'(off) + 2'd1;
            if (i_valid[probe]) begin
                winner = probe;
            end
        end
    end

    // Accept strobe: one-hot on the winner only when a transfer really
    // happens. It depends on i_valid, i_ready and state, but never on data.
    always_comb begin
        o_ready = 4'b0000;
        if (load) begin
            o_ready[winner] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    // A load has priority over a drain, so a simultaneous drain and load keeps
    // valid high. A drain alone only clears valid; the stale data and source
    // are left in place. With no transfer, everything holds.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_reg        <= '0;
            src_reg        <= 2'd0;
            valid_reg      <= 1'b0;
            // Starting the pointer at 3 gives channel 0 the first grant.
            last_grant_reg <= 2'd3;
        end else if (load) begin
            out_reg        <= chan_data[winner];
            src_reg        <= winner;
            valid_reg      <= 1'b1;
            last_grant_reg <= winner;
        end else if (valid_reg && i_ready) begin
            valid_reg      <= 1'b0;
        end
    end

    assign o_out   = out_reg;
    assign o_src   = src_reg;
    assign o_valid = valid_reg;

endmodule
